// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first via one full-subtractor cell and a borrow flop; done pulses WIDTH edges after start.
// No backpressure: start is only sampled in IDLE, so a start raised in RUN or DONE is dropped and the result is held until the next accepted start.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               overflow_q, overflow_d;

  logic               last_bit;
  logic               cell_d;
  logic               cell_brw;
  logic [WIDTH-1:0]   res_shift;

  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign cell_d    = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
  assign cell_brw  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
  assign res_shift = {cell_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      brw_q        <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      brw_q        <= brw_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    brw_d        = brw_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    if (state_q == IDLE && start) begin
      a_sh_d  = a;
      b_sh_d  = b;
      brw_d   = bin;
      cnt_d   = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
      res_d  = res_shift;
      brw_d  = cell_brw;
      cnt_d  = cnt_q + CNT_W'(1);
      // Publish straight from the shifter so results appear on the same edge that enters DONE.
      if (last_bit) begin
        diff_d       = res_shift;
        borrow_out_d = cell_brw;
        overflow_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
      end
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 with hand-computed expected results.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       bin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_diff = 8'h00;

  serial_subtractor #(.WIDTH(8), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until done is seen, capped so a silent DUT cannot hang the run.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (done) break;
    end
    if (!done) n = 99;
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic bv_in, input logic [7:0] exp_d, input logic exp_b,
                        input logic exp_o);
    int n;
    a = av; b = bv; bin = bv_in; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_diff_held_in_run"}, diff, prev_diff);
    wait_done(n);
    check({tag, "_latency"}, n, 8);
    check({tag, "_diff"}, diff, exp_d);
    check({tag, "_borrow"}, borrow_out, exp_b);
    check({tag, "_ovf"}, overflow, exp_o);
    check({tag, "_busy_in_done"}, busy, 1);
    tick();
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_diff_hold_idle"}, diff, exp_d);
    prev_diff = exp_d;
  endtask

  initial begin
    int n;
    int pulses;

    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    run_op("basic", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    run_op("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("sovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("sovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("bin_equal", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("bin_plain", 8'h20, 8'h05, 1'b1, 8'h1A, 1'b0, 1'b0);

    // Start raised at E0+3 must be dropped along with its operands.
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("ignore_latency", n, 5);
    check("ignore_diff", diff, 8'h02);
    check("ignore_borrow", borrow_out, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    check("ignore_no_second_done", pulses, 0);
    check("ignore_idle", busy, 0);

    // Reset sampled at E0+4 aborts the operation and clears results.
    a = 8'h33; b = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("midrst_stays_idle", pulses, 0);
    prev_diff = 8'h00;
    run_op("after_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- The inverse-direction companion to the team's combinational full adder: it uses one full-subtractor cell plus a borrow flip-flop instead of a ripple chain.
- It sits behind a start/busy/done handshake, so a controller can issue operations and collect results without tracking timing itself.

Parameters:
- WIDTH, 8, operand and result width in bits (legal values 2..32).
- CNT_W, 6, bit-width of the internal bit counter (must satisfy 2^CNT_W > WIDTH).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while an operation is in progress (RUN or DONE).
- done  output  1  single-cycle pulse marking that the result is valid.
- diff  output  WIDTH  result; held until the next accepted start.
- borrow_out  output  1  final borrow; set when the unsigned value a < b + bin.
- overflow  output  1  signed overflow of a - b - bin.

Behaviour:
- Reset: all of the following are forced to 0 on any edge with rst=1, from any state, including mid-operation: busy, done, diff, borrow_out, overflow, internal shift registers, counter, borrow flop. The FSM goes to IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with start=1. On that edge:
  - load a_sh <= a and b_sh <= b;
  - borrow flop <= bin;
  - cnt <= 0;
  - record sign bits a[WIDTH-1] and b[WIDTH-1].
- diff, borrow_out and overflow keep their old values until the operation completes.
- RUN, on each edge, with x = a_sh[0], y = b_sh[0], r = borrow flop:
  - d = x^y^r;
  - borrow flop <= (~x&y) | (~(x^y)&r);
  - shift d into the result register at the MSB and shift it right;
  - shift a_sh and b_sh right by 1;
  - cnt <= cnt+1.
- After the WIDTH-th RUN edge (cnt reached WIDTH-1 before it), the FSM enters DONE. On that edge:
  - diff <= the assembled result;
  - borrow_out <= final borrow;
  - overflow <= (a_msb != b_msb) && (diff[WIDTH-1] != a_msb).
- DONE: done=1 for exactly this one cycle, busy=1. The next edge returns to IDLE unconditionally.
- busy = 1 in RUN and DONE, and 0 in IDLE.
- Latency: start is accepted at edge E0. done is high in the cycle between edges E0+WIDTH and E0+WIDTH+1. A new start can be accepted at edge E0+WIDTH+1 at the earliest.
- start is ignored in RUN and DONE. No queuing: a start asserted during RUN is dropped, and operand changes during RUN have no effect.
- start held continuously high produces back-to-back operations every WIDTH+1 cycles.
- Arithmetic is modulo 2^WIDTH. Both borrow_out and overflow are defined for every input combination.
- bin=1 with a=b gives diff = all ones and borrow_out=1.

Test Plan (WIDTH=8):
- Basic subtraction: a=0x5A, b=0x23, bin=0, pulse start -> busy rises after E0; done pulses only at E0+8; diff=0x37, borrow_out=0, overflow=0.
- Unsigned underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow_out=1, overflow=0.
- Signed overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow_out=0, overflow=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- Borrow-in with equal operands: a=0x10, b=0x10, bin=1 -> diff=0xFF, borrow_out=1.
- Start ignored while busy: start a=0x05, b=0x03; at E0+3, assert start with a=0xFF, b=0x00 -> result is diff=0x02, and no second done pulse follows unless start is re-asserted in IDLE.
- Reset mid-operation: assert rst at E0+4 -> on the next edge busy=0, done=0, diff=0x00, FSM in IDLE. A following start with a=0x09, b=0x04 completes normally with diff=0x05, done pulsing 8 cycles after acceptance.
- Continuous start high (optional stress): done pulses every 9 cycles, and each result matches the operands present at its accepting edge.
